// File: rtl/rv_pkg.sv
// Shared definitions for the fetch stage: NOP encoding, instruction field positions and
// the fetch FSM state encoding.
package rv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int unsigned OP_MSB   = 6;
  localparam int unsigned OP_LSB   = 0;
  localparam int unsigned F3_MSB   = 14;
  localparam int unsigned F3_LSB   = 12;
  localparam int unsigned F7_BIT   = 30;
  localparam int unsigned F7_0_BIT = 25;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StHold  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding buffer for an {instr, pc} pair that arrived while decode was stalled.
module fetch_skid_buf
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic            unload_i,
  input  logic            flush_i,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            full_o,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o
);

  logic            full_q, full_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;

  always_comb begin
    full_d  = full_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush_i) begin
      full_d = 1'b0;
    end else if (load_i) begin
      full_d  = 1'b1;
      instr_d = instr_i;
      pc_d    = pc_i;
    end else if (unload_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      full_q  <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
    end else begin
      full_q  <= full_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign full_o  = full_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage with req/ack memory handshake, redirect handling and the IF/ID
// pipeline register feeding the control unit.
module fetch_unit
  import rv_pkg::*;
#(
  parameter int unsigned    XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pcSrc,
  input  logic [XLEN-1:0] pcTarget,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pcPlus4,
  output logic [6:0]      op,
  output logic [2:0]      f3,
  output logic            f7,
  output logic            f7_0
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] kill_target_q, kill_target_d;
  logic            valid_q, valid_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;

  logic            skid_load, skid_unload, skid_flush, skid_full;
  logic [31:0]     skid_instr;
  logic [XLEN-1:0] skid_pc;
  logic [XLEN-1:0] target_aligned;

  assign target_aligned = pcTarget & ~XLEN'(3);

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    kill_d        = kill_q;
    kill_target_d = kill_target_q;
    valid_d       = valid_q;
    instr_d       = instr_q;
    pc_d          = pc_q;
    pc_plus4_d    = pc_plus4_q;
    skid_load     = 1'b0;
    skid_unload   = 1'b0;
    skid_flush    = 1'b0;

    // Decode consumes IF/ID every unstalled cycle; a bubble follows unless refilled below.
    if (!stall) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end

    if (pcSrc) begin
      valid_d    = 1'b0;
      instr_d    = NOP_INSTR;
      skid_flush = 1'b1;
      if (state_q == StFetch && !imem_ack) begin
        // Request still in flight: let it complete, then drop its data.
        kill_d        = 1'b1;
        kill_target_d = target_aligned;
      end else begin
        fetch_pc_d = target_aligned;
        kill_d     = 1'b0;
        state_d    = StFetch;
      end
    end else begin
      unique case (state_q)
        StIdle: state_d = StFetch;
        StFetch: begin
          if (imem_ack) begin
            if (kill_q) begin
              fetch_pc_d = kill_target_q;
              kill_d     = 1'b0;
            end else if (stall) begin
              skid_load  = 1'b1;
              fetch_pc_d = fetch_pc_q + XLEN'(4);
              state_d    = StHold;
            end else begin
              valid_d    = 1'b1;
              instr_d    = imem_rdata;
              pc_d       = fetch_pc_q;
              pc_plus4_d = fetch_pc_q + XLEN'(4);
              fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
          end
        end
        StHold: begin
          if (!stall && skid_full) begin
            valid_d     = 1'b1;
            instr_d     = skid_instr;
            pc_d        = skid_pc;
            pc_plus4_d  = skid_pc + XLEN'(4);
            skid_unload = 1'b1;
            state_d     = StFetch;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      fetch_pc_q    <= RESET_PC;
      kill_q        <= 1'b0;
      kill_target_q <= '0;
      valid_q       <= 1'b0;
      instr_q       <= NOP_INSTR;
      pc_q          <= '0;
      pc_plus4_q    <= XLEN'(4);
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      kill_q        <= kill_d;
      kill_target_q <= kill_target_d;
      valid_q       <= valid_d;
      instr_q       <= instr_d;
      pc_q          <= pc_d;
      pc_plus4_q    <= pc_plus4_d;
    end
  end

  fetch_skid_buf #(
    .XLEN(XLEN)
  ) u_skid (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .load_i  (skid_load),
    .unload_i(skid_unload),
    .flush_i (skid_flush),
    .instr_i (imem_rdata),
    .pc_i    (fetch_pc_q),
    .full_o  (skid_full),
    .instr_o (skid_instr),
    .pc_o    (skid_pc)
  );

  assign imem_req  = (state_q == StFetch);
  assign imem_addr = fetch_pc_q;

  assign valid   = valid_q;
  assign instr   = instr_q;
  assign pc      = pc_q;
  assign pcPlus4 = pc_plus4_q;
  assign op      = instr_q[OP_MSB:OP_LSB];
  assign f3      = instr_q[F3_MSB:F3_LSB];
  assign f7      = instr_q[F7_BIT];
  assign f7_0    = instr_q[F7_0_BIT];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: wait-state memory responder, transaction-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pcSrc;
  logic [31:0] pcTarget;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic        f7;
  logic        f7_0;

  int checks = 0;
  int errors = 0;
  int ws     = 0;
  int wcnt   = 0;
  bit checking = 1'b0;

  fetch_unit #(
    .XLEN    (32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pcSrc     (pcSrc),
    .pcTarget  (pcTarget),
    .stall     (stall),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .valid     (valid),
    .instr     (instr),
    .pc        (pc),
    .pcPlus4   (pcPlus4),
    .op        (op),
    .f3        (f3),
    .f7        (f7),
    .f7_0      (f7_0)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[29:0], 2'b11} ^ 32'h5A00_0000;
  endfunction

  // Memory acks after ws wait cycles of a continuous request.
  always_comb begin
    imem_ack   = (imem_req === 1'b1) && (wcnt >= ws);
    imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
  end

  always @(posedge clk) begin
    if (imem_req !== 1'b1 || imem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference model: "live" once the post-reset idle cycle has passed, a queue for the
  // parked instruction, and a pending-discard flag for a redirect during a wait state.
  bit          m_live = 1'b0;
  logic [31:0] m_fpc = 32'h0;
  bit          m_kill = 1'b0;
  logic [31:0] m_ktgt = 32'h0;
  logic [63:0] m_skid[$];
  bit          m_valid = 1'b0;
  logic [31:0] m_instr = NOP;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_pc4 = 32'h4;

  task automatic model_step(input logic r, input logic ps, input logic [31:0] tgt_raw,
                            input logic st, input logic ack, input logic [31:0] rd);
    logic [31:0] tgt;
    logic        req;
    logic [63:0] e;
    tgt = tgt_raw & 32'hFFFF_FFFC;
    req = m_live && (m_skid.size() == 0);
    if (!r) begin
      m_live = 1'b0; m_fpc = 32'h0; m_kill = 1'b0; m_skid.delete();
      m_valid = 1'b0; m_instr = NOP; m_pc = 32'h0; m_pc4 = 32'h4;
    end else begin
      if (!st) begin
        m_valid = 1'b0;
        m_instr = NOP;
      end
      if (ps) begin
        m_valid = 1'b0;
        m_instr = NOP;
        m_skid.delete();
        if (req && ack !== 1'b1) begin
          m_kill = 1'b1;
          m_ktgt = tgt;
        end else begin
          m_fpc  = tgt;
          m_kill = 1'b0;
        end
        m_live = 1'b1;
      end else if (!m_live) begin
        m_live = 1'b1;
      end else if (m_skid.size() != 0) begin
        if (!st) begin
          e = m_skid.pop_front();
          m_valid = 1'b1;
          m_instr = e[63:32];
          m_pc    = e[31:0];
          m_pc4   = e[31:0] + 32'd4;
        end
      end else if (ack === 1'b1) begin
        if (m_kill) begin
          m_fpc  = m_ktgt;
          m_kill = 1'b0;
        end else if (st) begin
          m_skid.push_back({rd, m_fpc});
          m_fpc = m_fpc + 32'd4;
        end else begin
          m_valid = 1'b1;
          m_instr = rd;
          m_pc    = m_fpc;
          m_pc4   = m_fpc + 32'd4;
          m_fpc   = m_fpc + 32'd4;
        end
      end
    end
  endtask

  logic        stab_pend = 1'b0;
  logic [31:0] stab_addr = 32'h0;

  // Compare current DUT state with the model, then advance the model across the next edge.
  always @(negedge clk) begin
    logic exp_req;
    exp_req = m_live && (m_skid.size() == 0);
    if (checking) begin
      check("m_valid", 32'(valid), 32'(m_valid));
      check("m_instr", instr, m_instr);
      check("m_op", 32'(op), 32'(m_instr[6:0]));
      check("m_f3", 32'(f3), 32'(m_instr[14:12]));
      check("m_f7", 32'(f7), 32'(m_instr[30]));
      check("m_f7_0", 32'(f7_0), 32'(m_instr[25]));
      if (m_valid) begin
        check("m_pc", pc, m_pc);
        check("m_pcPlus4", pcPlus4, m_pc4);
      end
      check("m_req", 32'(imem_req), 32'(exp_req));
      if (exp_req) check("m_addr", imem_addr, m_fpc);
      if (stab_pend) check("addr_stable", imem_addr, stab_addr);
    end
    stab_pend = checking && (rst_n === 1'b1) && (imem_req === 1'b1) && !imem_ack;
    stab_addr = imem_addr;
    model_step(rst_n, pcSrc, pcTarget, stall, imem_ack, imem_rdata);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset(input int w);
    rst_n    = 1'b0;
    pcSrc    = 1'b0;
    stall    = 1'b0;
    pcTarget = 32'h0;
    ws       = w;
    ticks(2);
    checking = 1'b1;
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_instr", instr, NOP);
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_pcPlus4", pcPlus4, 32'h4);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    pcSrc    = 1'b0;
    stall    = 1'b0;
    pcTarget = 32'h0;

    // Zero-wait streaming, then a stall while the 0x10 response arrives.
    do_reset(0);
    tick();
    check("e1_req", 32'(imem_req), 32'h1);
    check("e1_addr", imem_addr, 32'h0);
    check("e1_valid", 32'(valid), 32'h0);
    tick();
    check("first_valid", 32'(valid), 32'h1);
    check("first_instr", instr, 32'h0050_0093);
    check("first_op", 32'(op), 32'h13);
    check("first_pc", pc, 32'h0);
    check("first_pcPlus4", pcPlus4, 32'h4);
    tick();
    check("seq_pc4", pc, 32'h4);
    tick();
    check("seq_pc8", pc, 32'h8);
    tick();
    check("seq_pc12", pc, 32'hC);
    stall = 1'b1;
    tick();
    check("hold_pc", pc, 32'hC);
    check("hold_valid", 32'(valid), 32'h1);
    check("hold_req", 32'(imem_req), 32'h0);
    tick();
    check("hold2_pc", pc, 32'hC);
    stall = 1'b0;
    tick();
    check("unhold_pc", pc, 32'h10);
    check("unhold_instr", instr, mem_word(32'h10));
    check("unhold_addr", imem_addr, 32'h14);
    check("unhold_req", 32'(imem_req), 32'h1);

    // Redirect and stall together: flush wins.
    pcSrc    = 1'b1;
    stall    = 1'b1;
    pcTarget = 32'h40;
    tick();
    check("flush_valid", 32'(valid), 32'h0);
    check("flush_instr", instr, NOP);
    check("flush_addr", imem_addr, 32'h40);
    pcSrc = 1'b0;
    stall = 1'b0;
    tick();
    check("redir_pc", pc, 32'h40);
    check("redir_valid", 32'(valid), 32'h1);

    // Redirect to the top word; low target bits ignored.
    pcSrc    = 1'b1;
    pcTarget = 32'hFFFF_FFFE;
    tick();
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    pcSrc = 1'b0;
    tick();
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    check("wrap_pcPlus4", pcPlus4, 32'h0);
    check("wrap_next_addr", imem_addr, 32'h0);
    tick();
    check("wrap_pc0", pc, 32'h0);

    // Two wait states per access.
    do_reset(2);
    tick();
    check("ws_addr_a", imem_addr, 32'h0);
    tick();
    check("ws_valid_a", 32'(valid), 32'h0);
    tick();
    check("ws_valid_b", 32'(valid), 32'h0);
    tick();
    check("ws_pc0", pc, 32'h0);
    check("ws_valid0", 32'(valid), 32'h1);
    check("ws_addr4", imem_addr, 32'h4);
    tick();
    check("ws_gap1_valid", 32'(valid), 32'h0);
    check("ws_gap1_addr", imem_addr, 32'h4);
    tick();
    check("ws_gap2_addr", imem_addr, 32'h4);
    tick();
    check("ws_pc4", pc, 32'h4);
    check("ws_addr8", imem_addr, 32'h8);
    ticks(6);
    check("ws_pcC", pc, 32'hC);
    check("ws_addr10", imem_addr, 32'h10);

    // Redirect while the 0x10 request waits: its data must be dropped.
    pcSrc    = 1'b1;
    pcTarget = 32'h103;
    tick();
    pcSrc = 1'b0;
    check("kill_valid", 32'(valid), 32'h0);
    check("kill_addr_held", imem_addr, 32'h10);
    tick();
    check("kill_valid2", 32'(valid), 32'h0);
    tick();
    check("kill_new_addr", imem_addr, 32'h100);
    check("kill_valid3", 32'(valid), 32'h0);

    // Reset in the middle of a wait state.
    rst_n = 1'b0;
    tick();
    check("midrst_req", 32'(imem_req), 32'h0);
    check("midrst_valid", 32'(valid), 32'h0);
    do_reset(0);
    tick();
    check("restart_addr", imem_addr, 32'h0);
    ticks(3);
    check("restart_pc", pc, 32'h8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
